// File: rtl/parallel_xor_descrambler.sv
// Parallel self-synchronised-free XOR descrambler: one W-bit word per cycle is XORed with
// W consecutive keystream bits of a 16-bit Fibonacci LFSR, behind a one-deep output register.
module parallel_xor_descrambler #(
    parameter int unsigned S = 3,
    localparam int unsigned W = 2 ** S
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [15:0]  seed,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [15:0]  word_count
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [15:0]    word_count_q, word_count_d;

    logic [W-1:0]   keystream;
    logic [15:0]    lfsr_adv;
    logic           in_hs;
    logic           out_hs;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Unroll W LFSR steps: bit i of the word sees the keystream bit of step i.
    always_comb begin
        lfsr_adv  = lfsr_q;
        keystream = '0;
        for (int unsigned i = 0; i < W; i++) begin
            keystream[i] = lfsr_adv[15];
            lfsr_adv     = lfsr_step(lfsr_adv);
        end
    end

    assign in_ready = (state_q == StRun) & ~seed_load & (~out_valid_q | out_ready);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        word_count_d = word_count_q;

        if (seed_load) begin
            state_d = StRun;
            // An all-zero seed would lock the LFSR at zero forever.
            lfsr_d  = (seed == 16'h0000) ? 16'hFFFF : seed;
        end else if (in_hs) begin
            lfsr_d = lfsr_adv;
        end

        if (in_hs) begin
            out_data_d  = in_data ^ keystream;
            out_valid_d = 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (out_hs && (word_count_q != 16'hFFFF)) begin
            word_count_d = word_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            lfsr_q       <= 16'hFFFF;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_parallel_xor_descrambler.sv
// Scoreboard bench: the driver pushes the expected output word on each accepted input and a
// negedge monitor pops and compares on every output handshake.
module tb_parallel_xor_descrambler;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] word_count;

    logic        rand_rdy;
    logic        rdy_fixed;
    logic        rnd_bit;
    logic [7:0]  exp_q[$];
    logic [15:0] m_lfsr;
    int          total;
    int          bad;

    assign out_ready = rand_rdy ? rnd_bit : rdy_fixed;

    parallel_xor_descrambler #(.S(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rnd_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] ks8(input logic [15:0] l);
        logic [7:0]  k;
        logic [15:0] t;
        t = l;
        for (int i = 0; i < 8; i++) begin
            k[i] = t[15];
            t = step(t);
        end
        return k;
    endfunction

    function automatic logic [15:0] adv8(input logic [15:0] l);
        logic [15:0] t;
        t = l;
        for (int i = 0; i < 8; i++) t = step(t);
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Output-side scoreboard: a handshake seen at negedge completes on the next posedge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {8'h00, out_data}, {8'h00, e});
                end
            end
        end
    end

    // All main-thread tasks start and end at posedge + #1.
    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        m_lfsr = adv8(m_lfsr);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        m_lfsr    = (s == 16'h0000) ? 16'hFFFF : s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_lfsr = 16'hFFFF;
    endtask

    initial begin
        logic [7:0] bp_exp;
        logic [7:0] p;
        logic [7:0] c;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        seed_load = 1'b0;
        seed      = 16'h0000;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        m_lfsr    = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, and IDLE refuses input.
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {15'h0, in_ready}, 16'h0000);
        check("rst_out_valid", {15'h0, out_valid}, 16'h0000);
        check("rst_out_data", {8'h00, out_data}, 16'h0000);
        check("rst_word_count", word_count, 16'h0000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Seed FFFF: first keystream byte FF, second byte FF.
        do_seed(16'hFFFF);
        send(8'h00, 8'hFF);
        send(8'hA5, 8'h5A);
        drain();
        check("wc_after_basic", word_count, 16'd2);

        // Backpressure: output held, input refused, LFSR frozen.
        rdy_fixed = 1'b0;
        bp_exp = 8'h3C ^ ks8(m_lfsr);
        send(8'h3C, bp_exp);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {15'h0, in_ready}, 16'h0000);
            check("bp_out_valid", {15'h0, out_valid}, 16'h0001);
            check("bp_out_data", {8'h00, out_data}, {8'h00, bp_exp});
        end
        @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        send(8'h77, 8'h77 ^ ks8(m_lfsr));
        drain();
        check("wc_after_bp", word_count, 16'd4);

        // Reseed with 1234 while in_valid is high: keystream byte is 8'h48.
        seed_load = 1'b1;
        seed      = 16'h1234;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        @(negedge clk);
        check("rs_in_ready", {15'h0, in_ready}, 16'h0000);
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        m_lfsr    = 16'h1234;
        send(8'h3C, 8'h74);
        drain();
        check("wc_after_reseed", word_count, 16'd5);

        // Zero seed behaves as FFFF.
        do_seed(16'h0000);
        send(8'h00, 8'hFF);
        drain();
        check("wc_after_zero", word_count, 16'd6);

        // Reset mid-operation with a pending word and word_count = 7.
        do_reset();
        do_seed(16'hFFFF);
        for (int i = 0; i < 7; i++) begin
            p = 8'(i * 37 + 5);
            send(p, p ^ ks8(m_lfsr));
        end
        drain();
        rdy_fixed = 1'b0;
        send(8'hAA, 8'hAA ^ ks8(m_lfsr));
        @(negedge clk);
        check("ro_wc_before", word_count, 16'd7);
        check("ro_valid_before", {15'h0, out_valid}, 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        in_valid  = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_lfsr = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ro_out_valid", {15'h0, out_valid}, 16'h0000);
            check("ro_word_count", word_count, 16'h0000);
            check("ro_in_ready", {15'h0, in_ready}, 16'h0000);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Loopback of 1000 random words through a model scrambler seeded with ACE1.
        do_reset();
        do_seed(16'hACE1);
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            p = 8'($urandom);
            c = p ^ ks8(m_lfsr);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(c, p);
        end
        drain();
        rand_rdy = 1'b0;
        @(negedge clk);
        check("lb_word_count", word_count, 16'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parallel_xor_descrambler.md
PARALLEL_XOR_DESCRAMBLER -- requirements
Module: parallel_xor_descrambler

Interface
REQ-001 Parameter: S, default 3, sets the data word width W = 2**S bits.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: seed_load  input  1  loads seed into the LFSR and enters RUN.
REQ-005 Port: seed  input  16  LFSR seed value.
REQ-006 Port: in_valid  input  1  scrambled input word available.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: in_data  input  W  scrambled input word.
REQ-009 Port: out_valid  output  1  descrambled word available.
REQ-010 Port: out_ready  input  1  downstream accepts out_data.
REQ-011 Port: out_data  output  W  descrambled word.
REQ-012 Port: word_count  output  16  count of output handshakes completed; saturates at 16'hFFFF.

Function
REQ-013 Keystream: 16-bit Fibonacci LFSR; keystream bit = lfsr[15]; per step, fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] and lfsr <= {lfsr[14:0], fb}.
REQ-014 On acceptance, bit i of in_data (i = 0 is the LSB) is XORed with the keystream bit of step i; the LFSR advances exactly W steps per accepted word.
REQ-015 Descrambling is a per-bit XOR with the same keystream the transmit side uses, so descramble(scramble(x)) = x when both ends use the same seed.
REQ-016 States: IDLE (unseeded) and RUN; IDLE -> RUN on seed_load; RUN -> RUN on seed_load (reseed); no other transitions; rst -> IDLE from either state.
REQ-017 Seed 16'h0000 is replaced by 16'hFFFF at load, which avoids LFSR lock-up.
REQ-018 in_ready = (state == RUN) & !seed_load & (!out_valid | out_ready).
REQ-019 Input handshake (in_valid & in_ready): in_data XOR keystream is registered into out_data, out_valid goes to 1, and the LFSR advances W steps; the result appears on out_data in the next cycle (latency 1).
REQ-020 Output handshake (out_valid & out_ready) with no input handshake in the same cycle: out_valid goes to 0.
REQ-021 Input and output handshakes in the same cycle: the new word replaces the old word and out_valid stays 1, giving full throughput of one word per cycle.
REQ-022 While out_valid = 1 and out_ready = 0: out_data and out_valid stay stable, and the LFSR does not advance.
REQ-023 A seed_load in RUN takes priority over the input handshake: no input is accepted that cycle; any pending out_data/out_valid is kept and is delivered normally; words accepted afterwards use the new seed.
REQ-024 In IDLE: in_ready = 0; a pending output word is still delivered.
REQ-025 word_count increments by 1 on each output handshake and holds at 16'hFFFF once it reaches that value; seed_load does not clear it.

Reset
REQ-026 On rst = 1 at a clock edge: state = IDLE, lfsr = 16'hFFFF, out_valid = 0, out_data = 0, word_count = 0, and in_ready = 0 in the following cycle.
REQ-027 rst overrides seed_load and both handshakes in the same cycle; an in-flight word is discarded.

Verification
REQ-028 The bench shall drive reset, then seed_load with seed = 16'hFFFF, then in_data = 8'h00 with S = 3 and out_ready = 1; required response: out_data = 8'hFF one cycle later, then out_data = 8'h5A for a following in_data = 8'hA5.
REQ-029 The bench shall check loopback: 1000 random words are scrambled by a reference model with seed 16'hACE1, passed through the DUT with the same seed and random in_valid/out_ready; required response: output equals the plaintext in order, and word_count = 1000.
REQ-030 The bench shall check backpressure: out_ready = 0 for 5 cycles with out_valid = 1; required response: in_ready = 0, and out_data and the LFSR are unchanged until out_ready rises.
REQ-031 The bench shall check a mid-stream reseed: seed_load with 16'h1234 is asserted together with in_valid; required response: the word is not accepted that cycle, and the next accepted word is descrambled with the keystream from 16'h1234.
REQ-032 The bench shall check the zero seed: seed_load with 16'h0000 followed by in_data = 8'h00; required response: out_data = 8'hFF, i.e. the seed 16'hFFFF substitution is applied.
REQ-033 The bench shall check reset mid-operation: rst is asserted with out_valid = 1 and word_count = 7; required response: the next cycle shows out_valid = 0, word_count = 0 and in_ready = 0 until the next seed_load.
